// File: rtl/tmds_encoder_mc.sv
// Multi-lane TMDS encoder: stage 1 applies transition-minimising coding, stage 2 DC balance.
// Define TMDS_ENCODER_MC_TERC4_EN to enable the TERC4 data-island modes 3 and 4.
module tmds_encoder_mc #(
  parameter int CHANNELS = 3,
  parameter int CH_BASE  = 0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [2:0]             mode,
  input  logic [8*CHANNELS-1:0]  d,
  input  logic [2*CHANNELS-1:0]  ctl,
  input  logic [4*CHANNELS-1:0]  aux,
  output logic [10*CHANNELS-1:0] d_out,
  output logic [5*CHANNELS-1:0]  disp
);

  typedef enum logic [2:0] {
    MODE_CTRL   = 3'd0,
    MODE_VIDEO  = 3'd1,
    MODE_VGUARD = 3'd2,
    MODE_ISLAND = 3'd3,
    MODE_IGUARD = 3'd4
  } mode_e;

  localparam logic [9:0] CTRL_RESET = 10'b1101010100;

  function automatic logic [9:0] ctrl_code(input logic [1:0] c);
    case (c)
      2'b00:   ctrl_code = 10'b1101010100;
      2'b01:   ctrl_code = 10'b0010101011;
      2'b10:   ctrl_code = 10'b0101010100;
      default: ctrl_code = 10'b1010101011;
    endcase
  endfunction

`ifdef TMDS_ENCODER_MC_TERC4_EN
  function automatic logic [9:0] terc4(input logic [3:0] n);
    case (n)
      4'h0:    terc4 = 10'b1010011100;
      4'h1:    terc4 = 10'b1001100011;
      4'h2:    terc4 = 10'b1011100100;
      4'h3:    terc4 = 10'b1011100010;
      4'h4:    terc4 = 10'b0101110001;
      4'h5:    terc4 = 10'b0100011110;
      4'h6:    terc4 = 10'b0110001110;
      4'h7:    terc4 = 10'b0100111100;
      4'h8:    terc4 = 10'b1011001100;
      4'h9:    terc4 = 10'b0100111001;
      4'hA:    terc4 = 10'b0110011100;
      4'hB:    terc4 = 10'b1011000111;
      4'hC:    terc4 = 10'b1010001110;
      4'hD:    terc4 = 10'b1001110001;
      4'hE:    terc4 = 10'b0101100011;
      default: terc4 = 10'b1011000011;
    endcase
  endfunction
`else
  logic aux_unused;
  assign aux_unused = ^aux;
`endif

  // Reserved (and, without TERC4, data-island) modes collapse to control here,
  // so stage 2 only ever sees the modes it actually implements.
  mode_e mode_dec;
  mode_e mode_q;

  always_comb begin
    mode_dec = MODE_CTRL;
    case (mode)
      3'd1:    mode_dec = MODE_VIDEO;
      3'd2:    mode_dec = MODE_VGUARD;
`ifdef TMDS_ENCODER_MC_TERC4_EN
      3'd3:    mode_dec = MODE_ISLAND;
      3'd4:    mode_dec = MODE_IGUARD;
`endif
      default: mode_dec = MODE_CTRL;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) mode_q <= MODE_CTRL;
    else        mode_q <= mode_dec;
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_lane
    localparam int HDMI_LANE = CH_BASE + i;
    localparam logic [9:0] GUARD_CODE = (HDMI_LANE == 1) ? 10'b0100110011 : 10'b1011001100;

    logic [7:0]        din;
    logic [3:0]        din_ones;
    logic              use_xnor;
    logic [8:0]        qm_next;
    logic [8:0]        qm_q;
    logic [3:0]        n1_q;
    logic [1:0]        ctl_q;
    logic [9:0]        sym_next;
    logic [9:0]        sym_q;
    logic signed [4:0] disp_next;
    logic signed [4:0] disp_q;
    logic signed [4:0] n1_s;
    logic signed [4:0] n0_s;
    logic signed [4:0] bal;

    assign din      = d[8*i +: 8];
    assign din_ones = 4'($countones(din));
    assign use_xnor = (din_ones > 4'd4) || (din_ones == 4'd4 && !din[0]);

    always_comb begin
      qm_next    = '0;
      qm_next[0] = din[0];
      for (int b = 1; b < 8; b++)
        qm_next[b] = use_xnor ? ~(qm_next[b-1] ^ din[b]) : (qm_next[b-1] ^ din[b]);
      qm_next[8] = ~use_xnor;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        qm_q  <= '0;
        n1_q  <= '0;
        ctl_q <= '0;
      end else begin
        qm_q  <= qm_next;
        n1_q  <= 4'($countones(qm_next[7:0]));
        ctl_q <= ctl[2*i +: 2];
      end
    end

`ifdef TMDS_ENCODER_MC_TERC4_EN
    logic [3:0] aux_q;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) aux_q <= '0;
      else        aux_q <= aux[4*i +: 4];
    end
`endif

    // bal is N1-N0 of the stage-1 word; the disparity sign bit stands in for disp<0.
    assign n1_s = signed'({1'b0, n1_q});
    assign n0_s = 5'sd8 - n1_s;
    assign bal  = n1_s - n0_s;

    always_comb begin
      sym_next  = ctrl_code(ctl_q);
      disp_next = '0;
      case (mode_q)
        MODE_VIDEO: begin
          if (disp_q == 5'sd0 || n1_q == 4'd4) begin
            sym_next  = {~qm_q[8], qm_q[8], qm_q[8] ? qm_q[7:0] : ~qm_q[7:0]};
            disp_next = qm_q[8] ? (disp_q + bal) : (disp_q - bal);
          end else if ((!disp_q[4] && n1_q > 4'd4) || (disp_q[4] && n1_q < 4'd4)) begin
            sym_next  = {1'b1, qm_q[8], ~qm_q[7:0]};
            disp_next = disp_q - bal + (qm_q[8] ? 5'sd2 : 5'sd0);
          end else begin
            sym_next  = {1'b0, qm_q[8], qm_q[7:0]};
            disp_next = disp_q + bal - (qm_q[8] ? 5'sd0 : 5'sd2);
          end
        end
        MODE_VGUARD: sym_next = GUARD_CODE;
`ifdef TMDS_ENCODER_MC_TERC4_EN
        MODE_ISLAND: sym_next = terc4(aux_q);
        MODE_IGUARD: sym_next = (HDMI_LANE == 0) ? terc4({2'b11, ctl_q}) : 10'b0100110011;
`endif
        default: ;
      endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sym_q  <= CTRL_RESET;
        disp_q <= '0;
      end else begin
        sym_q  <= sym_next;
        disp_q <= disp_next;
      end
    end

    assign d_out[10*i +: 10] = sym_q;
    assign disp[5*i +: 5]    = disp_q;
  end

endmodule

// File: tb/tb_tmds_encoder_mc.sv
// Self-checking bench for tmds_encoder_mc (CHANNELS=3, CH_BASE=0): an arithmetic model
// compared every cycle, plus hand-computed directed vectors.
module tb_tmds_encoder_mc;

  localparam int CH = 3;
  localparam logic [9:0] RESET_SYM = 10'b1101010100;
`ifdef TMDS_ENCODER_MC_TERC4_EN
  localparam bit TERC4_ON = 1'b1;
`else
  localparam bit TERC4_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  mode;
  logic [23:0] d;
  logic [5:0]  ctl;
  logic [11:0] aux;
  logic [29:0] d_out;
  logic [14:0] disp;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  tmds_encoder_mc #(.CHANNELS(CH), .CH_BASE(0)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .mode  (mode),
    .d     (d),
    .ctl   (ctl),
    .aux   (aux),
    .d_out (d_out),
    .disp  (disp)
  );

  function automatic logic [9:0] ctrl_sym(input logic [1:0] c);
    case (c)
      2'b00:   return 10'b1101010100;
      2'b01:   return 10'b0010101011;
      2'b10:   return 10'b0101010100;
      default: return 10'b1010101011;
    endcase
  endfunction

  function automatic logic [9:0] terc4_sym(input logic [3:0] n);
    case (n)
      4'h0: return 10'b1010011100;  4'h1: return 10'b1001100011;
      4'h2: return 10'b1011100100;  4'h3: return 10'b1011100010;
      4'h4: return 10'b0101110001;  4'h5: return 10'b0100011110;
      4'h6: return 10'b0110001110;  4'h7: return 10'b0100111100;
      4'h8: return 10'b1011001100;  4'h9: return 10'b0100111001;
      4'hA: return 10'b0110011100;  4'hB: return 10'b1011000111;
      4'hC: return 10'b1010001110;  4'hD: return 10'b1001110001;
      4'hE: return 10'b0101100011;  default: return 10'b1011000011;
    endcase
  endfunction

  // Returns {symbol, new 5-bit disparity} for one video byte, using integer disparity.
  function automatic logic [14:0] video_encode(input logic [7:0] dv, input int rd);
    int ones, n1, n0, nrd;
    bit xnor_sel;
    logic [8:0] qm;
    logic [9:0] sym;
    ones = $countones(dv);
    xnor_sel = (ones > 4) || (ones == 4 && dv[0] == 1'b0);
    qm = '0;
    qm[0] = dv[0];
    for (int b = 1; b < 8; b++)
      qm[b] = xnor_sel ? ~(qm[b-1] ^ dv[b]) : (qm[b-1] ^ dv[b]);
    qm[8] = !xnor_sel;
    n1 = $countones(qm[7:0]);
    n0 = 8 - n1;
    if (rd == 0 || n1 == n0) begin
      sym = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
      nrd = qm[8] ? rd + n1 - n0 : rd + n0 - n1;
    end else if ((rd > 0 && n1 > n0) || (rd < 0 && n0 > n1)) begin
      sym = {1'b1, qm[8], ~qm[7:0]};
      nrd = rd + (qm[8] ? 2 : 0) + n0 - n1;
    end else begin
      sym = {1'b0, qm[8], qm[7:0]};
      nrd = rd - (qm[8] ? 0 : 2) + n1 - n0;
    end
    return {sym, nrd[4:0]};
  endfunction

  function automatic logic [9:0] nonvideo_sym(input logic [2:0] m, input logic [1:0] c,
                                              input logic [3:0] a, input int lane);
    if (m == 3'd2) return (lane == 1) ? 10'b0100110011 : 10'b1011001100;
    if (TERC4_ON && m == 3'd3) return terc4_sym(a);
    if (TERC4_ON && m == 3'd4) return (lane == 0) ? terc4_sym({2'b11, c}) : 10'b0100110011;
    return ctrl_sym(c);
  endfunction

  function automatic logic [7:0] tmds_decode(input logic [9:0] s);
    logic [7:0] q;
    logic [7:0] o;
    q = s[9] ? ~s[7:0] : s[7:0];
    o[0] = q[0];
    for (int b = 1; b < 8; b++)
      o[b] = s[8] ? (q[b] ^ q[b-1]) : ~(q[b] ^ q[b-1]);
    return o;
  endfunction

  // Two-entry expectation pipeline mirroring the two-edge latency; s2 is what d_out must show.
  logic [9:0] s1_sym [CH];
  logic [9:0] s2_sym [CH];
  logic [4:0] s1_rd [CH];
  logic [4:0] s2_rd [CH];
  logic [7:0] s1_d [CH];
  logic [7:0] s2_d [CH];
  bit         s1_vid, s2_vid;
  int         model_rd [CH];

  always @(posedge clk or negedge rst_n) begin
    logic [14:0] res;
    if (!rst_n) begin
      s1_vid = 1'b0;
      s2_vid = 1'b0;
      for (int l = 0; l < CH; l++) begin
        s1_sym[l] = RESET_SYM; s2_sym[l] = RESET_SYM;
        s1_rd[l] = '0; s2_rd[l] = '0; s1_d[l] = '0; s2_d[l] = '0;
        model_rd[l] = 0;
      end
    end else begin
      s2_vid = s1_vid;
      s1_vid = (mode == 3'd1);
      for (int l = 0; l < CH; l++) begin
        s2_sym[l] = s1_sym[l]; s2_rd[l] = s1_rd[l]; s2_d[l] = s1_d[l];
        s1_d[l] = d[8*l +: 8];
        if (mode == 3'd1) begin
          res = video_encode(d[8*l +: 8], model_rd[l]);
          s1_sym[l] = res[14:5];
          model_rd[l] = int'($signed(res[4:0]));
        end else begin
          s1_sym[l] = nonvideo_sym(mode, ctl[2*l +: 2], aux[4*l +: 4], l);
          model_rd[l] = 0;
        end
        s1_rd[l] = model_rd[l][4:0];
      end
    end
  end

  always @(negedge clk) begin
    for (int l = 0; l < CH; l++) begin
      checks++;
      if (d_out[10*l +: 10] !== s2_sym[l]) begin
        errors++;
        $display("[TB] FAIL model_sym lane%0d t=%0t d_out got %b expected %b", l, $time, d_out[10*l +: 10], s2_sym[l]);
      end
      checks++;
      if (disp[5*l +: 5] !== s2_rd[l]) begin
        errors++;
        $display("[TB] FAIL model_disp lane%0d t=%0t disp got %b expected %b", l, $time, disp[5*l +: 5], s2_rd[l]);
      end
      if (s2_vid) begin
        checks++;
        if (tmds_decode(d_out[10*l +: 10]) !== s2_d[l]) begin
          errors++;
          $display("[TB] FAIL decode lane%0d t=%0t decoded %h expected %h", l, $time, tmds_decode(d_out[10*l +: 10]), s2_d[l]);
        end
      end
    end
  end

  task automatic applyStimulus(input logic [2:0] m, input logic [23:0] dv,
                               input logic [5:0] c, input logic [11:0] a);
    mode = m; d = dv; ctl = c; aux = a;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic checkOutput(input string name, input int lane,
                             input logic [9:0] exp_sym, input logic [4:0] exp_disp);
    checks++;
    if (d_out[10*lane +: 10] !== exp_sym) begin
      errors++;
      $display("[TB] FAIL %s lane%0d d_out got %b expected %b", name, lane, d_out[10*lane +: 10], exp_sym);
    end
    checks++;
    if (disp[5*lane +: 5] !== exp_disp) begin
      errors++;
      $display("[TB] FAIL %s lane%0d disp got %b expected %b", name, lane, disp[5*lane +: 5], exp_disp);
    end
  endtask

  task automatic checkModel(input string name, input logic [14:0] got, input logic [14:0] exp_v);
    checks++;
    if (got !== exp_v) begin
      errors++;
      $display("[TB] FAIL %s model got %b expected %b", name, got, exp_v);
    end
  endtask

  logic [9:0]  ctrl_lit [4];
  logic [1:0]  cc;
  logic [2:0]  rm;

  initial begin
    mode = '0; d = '0; ctl = '0; aux = '0; rst_n = 1'b0;
    ctrl_lit[0] = 10'b1101010100; ctrl_lit[1] = 10'b0010101011;
    ctrl_lit[2] = 10'b0101010100; ctrl_lit[3] = 10'b1010101011;

    checkModel("model_v00_rd0",  video_encode(8'h00, 0),  {10'b0100000000, 5'b11000});
    checkModel("model_v00_rdm8", video_encode(8'h00, -8), {10'b1111111111, 5'b00010});
    checkModel("model_vff_rd0",  video_encode(8'hFF, 0),  {10'b1000000000, 5'b11000});

    repeat (3) @(negedge clk);
    for (int l = 0; l < CH; l++) checkOutput("reset", l, RESET_SYM, 5'd0);

    rst_n = 1'b1;
    applyStimulus(3'd1, 24'h0, 6'h0, 12'h0);
    for (int l = 0; l < CH; l++) checkOutput("first_after_reset", l, RESET_SYM, 5'd0);
    applyStimulus(3'd1, 24'h0, 6'h0, 12'h0);
    for (int l = 0; l < CH; l++) checkOutput("video00_first", l, 10'b0100000000, 5'b11000);
    applyStimulus(3'd0, 24'h0, 6'b111111, 12'h0);
    for (int l = 0; l < CH; l++) checkOutput("video00_second", l, 10'b1111111111, 5'b00010);
    applyStimulus(3'd0, 24'h0, 6'b111111, 12'h0);
    for (int l = 0; l < CH; l++) checkOutput("ctl11_clears_disp", l, 10'b1010101011, 5'd0);

    applyStimulus(3'd2, 24'hA5A5A5, 6'h0, 12'h0);
    applyStimulus(3'd2, 24'hA5A5A5, 6'h0, 12'h0);
    checkOutput("vguard_lane0", 0, 10'b1011001100, 5'd0);
    checkOutput("vguard_lane1", 1, 10'b0100110011, 5'd0);
    checkOutput("vguard_lane2", 2, 10'b1011001100, 5'd0);

    for (int c = 0; c < 4; c++) begin
      cc = c[1:0];
      applyStimulus(3'd0, 24'h0, {3{cc}}, 12'h0);
      applyStimulus(3'd0, 24'h0, {3{cc}}, 12'h0);
      for (int l = 0; l < CH; l++) checkOutput("ctrl_code", l, ctrl_lit[c], 5'd0);
    end

    for (int m = 5; m < 8; m++) begin
      rm = m[2:0];
      applyStimulus(rm, 24'h123456, 6'b010101, 12'hFFF);
      applyStimulus(rm, 24'h123456, 6'b010101, 12'hFFF);
      for (int l = 0; l < CH; l++) checkOutput("reserved_mode", l, 10'b0010101011, 5'd0);
    end

`ifdef TMDS_ENCODER_MC_TERC4_EN
    applyStimulus(3'd3, 24'h0, 6'h0, 12'h555);
    applyStimulus(3'd3, 24'h0, 6'h0, 12'h555);
    for (int l = 0; l < CH; l++) checkOutput("terc4_aux5", l, 10'b0100011110, 5'd0);
    applyStimulus(3'd4, 24'h0, 6'b000010, 12'h0);
    applyStimulus(3'd4, 24'h0, 6'b000010, 12'h0);
    checkOutput("island_guard_lane0", 0, 10'b0101100011, 5'd0);
    checkOutput("island_guard_lane1", 1, 10'b0100110011, 5'd0);
    checkOutput("island_guard_lane2", 2, 10'b0100110011, 5'd0);
`else
    applyStimulus(3'd3, 24'h0, 6'b010101, 12'h555);
    applyStimulus(3'd3, 24'h0, 6'b010101, 12'h555);
    for (int l = 0; l < CH; l++) checkOutput("mode3_as_ctrl", l, 10'b0010101011, 5'd0);
    applyStimulus(3'd4, 24'h0, 6'b101010, 12'h0);
    applyStimulus(3'd4, 24'h0, 6'b101010, 12'h0);
    for (int l = 0; l < CH; l++) checkOutput("mode4_as_ctrl", l, 10'b0101010100, 5'd0);
`endif

    for (int i = 0; i < 2000; i++) begin
      applyStimulus(3'd1, 24'($urandom), 6'($urandom), 12'($urandom));
      if (i == 1000) begin
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        for (int l = 0; l < CH; l++) checkOutput("async_reset", l, RESET_SYM, 5'd0);
        @(negedge clk);
        rst_n = 1'b1;
      end
    end

    for (int i = 0; i < 600; i++) begin
      rm = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 1) == 1) rm = 3'd1;
      applyStimulus(rm, 24'($urandom), 6'($urandom), 12'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
